voice_mixer_n: RTL
==================

# voice_mixer_n

Parametrised N-voice wavetable mixer. It sits between the note/octave decoding stage and the audio DAC path. It runs one phase accumulator per voice and time-multiplexes a single shared, synchronous wave ROM across all voices. On each sample tick it sums the enabled voices into one registered output sample. It generalises the fixed 3-voice, divided-clock datapath to N voices, adds fine phase-increment tuning, overrun detection and optional saturation, and uses a single clock domain.

## Interface
Parameters:
- NUM_VOICES, 3: voice count, ≥1
- ACC_W, 20: phase accumulator width
- ADDR_W, 12: ROM address width; address = acc[ACC_W-1 -: ADDR_W]
- SAMPLE_W, 8: unsigned ROM sample width
- OUT_W, 10: output width; internal sum width SUM_W = SAMPLE_W + $clog2(NUM_VOICES) (min SAMPLE_W)

Ports:
- clk  in  1  single clock; all state on posedge
- rst_n  in  1  asynchronous, active-low reset
- sample_tick  in  1  one-cycle strobe that starts a sweep
- voice_inc  in  NUM_VOICES*ACC_W  per-voice phase increment; voice k at [k*ACC_W +: ACC_W]
- voice_wave  in  NUM_VOICES*2  per-voice waveform: 0 sine, 1 triangle, 2 square, 3 saw
- voice_en  in  NUM_VOICES  per-voice enable
- rom_addr  out  ADDR_W  shared ROM address
- rom_sel  out  2  shared ROM waveform select
- rom_data  in  SAMPLE_W  ROM read data, valid one cycle after address
- out  out  OUT_W  mixed sample, held between updates
- out_valid  out  1  one-cycle pulse when out updates
- busy  out  1  sweep in progress
- overrun  out  1  sticky: tick arrived while busy
- overrun_clr  in  1  clears overrun

## Operation
States and transitions:
- IDLE → ISSUE on sample_tick; slot ← 0; sum ← 0.
- ISSUE: one slot per cycle. rom_addr and rom_sel are registered from acc[slot] and voice_wave[slot].
  - If voice_en[slot]: acc[slot] ← acc[slot] + voice_inc[slot], wrapping mod 2^ACC_W.
  - Else: acc[slot] ← 0. This is phase reset on disable.
  - After slot NUM_VOICES-1 → DRAIN.
- Capture runs alongside ISSUE. Each rom_data beat is added to sum, gated by the enable captured at issue time. Disabled voices contribute 0.
- DRAIN: waits for the final data beat → IDLE. On that edge out is loaded and out_valid is pulsed.
- busy is high in ISSUE and DRAIN.

Arithmetic:
- sum is unsigned, SUM_W bits. It cannot overflow.
- out = sum reduced to OUT_W per Configuration. If OUT_W ≥ SUM_W, out is zero-extended.

Boundary conditions:
- sample_tick while busy: the tick is dropped, overrun ← 1, and the sweep is unaffected.
- overrun set and overrun_clr in the same cycle: set wins.
- voice_inc and voice_en are sampled at each voice's issue edge only.
- rom_addr and rom_sel hold their last value in IDLE.
- NUM_VOICES = 1: one ISSUE cycle, then DRAIN.
- Reset mid-sweep: the sweep is aborted, no out_valid is produced, and the next tick starts at slot 0.

Reset values:
- state IDLE
- all acc 0
- slot 0, sum 0
- rom_addr 0, rom_sel 0
- out 0, out_valid 0, busy 0, overrun 0

## Timing
- Edge E0 samples sample_tick high. Voice k's address is presented after edge E0+1+k and captured at edge E0+2+k.
- out and out_valid update at edge E0+NUM_VOICES+2.
- busy is high from E0+1 through the cycle before out_valid.
- Minimum tick spacing is NUM_VOICES+2 cycles. A tick coincident with the out_valid cycle is accepted; busy is already low then.

## Configuration
- VOICE_MIXER_SAT_EN defined: when sum > 2^OUT_W−1, out = 2^OUT_W−1 (clamp).
- VOICE_MIXER_SAT_EN undefined: out = sum[OUT_W-1:0] (wrap).
- With OUT_W ≥ SUM_W the two modes are identical.

## Test plan
All scenarios use a ROM model that returns addr[7:0], with 1-cycle latency, unless stated otherwise.
- Defaults, all voices enabled, voice_inc = 0x100 each. Tick 1 → out=0. Tick 2 → out=3. out_valid pulses exactly once per tick at E0+5.
- voice_en = 3'b101, voice_inc = 0x100. Middle voice contributes 0 and its acc stays 0. Tick 3 → out=4.
- Second tick 2 cycles after the first → overrun=1, a single out_valid, result unchanged. overrun_clr → overrun=0. Clear and a new overrun in the same cycle → overrun stays 1.
- OUT_W=9, ROM forced to 0xFF, 3 voices → sum 765. Without macro out=253; with VOICE_MIXER_SAT_EN out=511.
- acc preloaded to 0xFFF00 via inc sweeps, then inc 0x100 → acc wraps to 0x00000 and the next sweep's rom_addr is 0.
- rst_n low during slot 1 → all outputs 0 immediately (asynchronous), no out_valid. After release, a tick issues slot 0 first and out_valid follows at E0+5.

Source files
------------

// File: rtl/voice_mixer_n.sv
// voice_mixer_n: N-voice wavetable mixer sharing one synchronous wave ROM.
// One phase accumulator per voice; each sample_tick sweeps all voices through
// the ROM one slot per cycle and sums the enabled voices into a registered output.
// Optional feature macro: VOICE_MIXER_SAT_EN (clamp instead of wrap when the sum
// does not fit in OUT_W bits).
module voice_mixer_n #(
    parameter int NUM_VOICES = 3,
    parameter int ACC_W      = 20,
    parameter int ADDR_W     = 12,
    parameter int SAMPLE_W   = 8,
    parameter int OUT_W      = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        sample_tick,
    input  logic [NUM_VOICES*ACC_W-1:0] voice_inc,
    input  logic [NUM_VOICES*2-1:0]     voice_wave,
    input  logic [NUM_VOICES-1:0]       voice_en,
    output logic [ADDR_W-1:0]           rom_addr,
    output logic [1:0]                  rom_sel,
    input  logic [SAMPLE_W-1:0]         rom_data,
    output logic [OUT_W-1:0]            out,
    output logic                        out_valid,
    output logic                        busy,
    output logic                        overrun,
    input  logic                        overrun_clr
);
    localparam int SUM_W  = SAMPLE_W + $clog2(NUM_VOICES);
    localparam int SLOT_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [SLOT_W-1:0]  slot;
    logic [ACC_W-1:0]   acc [NUM_VOICES];
    logic [SUM_W-1:0]   sum;
    logic [SUM_W-1:0]   sum_next;
    logic [OUT_W-1:0]   out_next;

    // Two-stage tag pipeline that travels alongside each ROM read:
    // iss_* is set on the issue edge, rd_* when rom_data for that slot is valid.
    logic               iss_valid;
    logic               iss_en;
    logic               iss_last;
    logic               rd_valid;
    logic               rd_en;
    logic               rd_last;

    assign busy = (state != IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: sweep slots, then wait for the last ROM beat to land
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sample_tick) state_next = ISSUE;
            ISSUE:   if (slot == LAST_SLOT) state_next = DRAIN;
            DRAIN:   if (rd_valid && rd_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Phase accumulators: advance on the voice's issue edge, or reset when disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                acc[v] <= '0;
            end
        end else if (state == ISSUE) begin
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                if (slot == SLOT_W'(v)) begin
                    if (voice_en[v]) begin
                        acc[v] <= acc[v] + voice_inc[v*ACC_W +: ACC_W];
                    end else begin
                        acc[v] <= '0;
                    end
                end
            end
        end
    end

    // Accumulate the current beat, contributing nothing for voices disabled at issue
    always_comb begin
        sum_next = sum;
        if (rd_en) begin
            sum_next = sum + SUM_W'(rom_data);
        end
    end

    // Reduce the final sum to the output width
    generate
        if (OUT_W >= SUM_W) begin : g_extend
            assign out_next = OUT_W'(sum_next);
        end else begin : g_reduce
`ifdef VOICE_MIXER_SAT_EN
            localparam logic [SUM_W-1:0] OUT_MAX = SUM_W'({OUT_W{1'b1}});
            assign out_next = (sum_next > OUT_MAX) ? '1 : sum_next[OUT_W-1:0];
`else
            assign out_next = sum_next[OUT_W-1:0];
`endif
        end
    endgenerate

    // Datapath: slot counter, ROM request, tag pipeline, running sum and output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot      <= '0;
            sum       <= '0;
            rom_addr  <= '0;
            rom_sel   <= '0;
            iss_valid <= 1'b0;
            iss_en    <= 1'b0;
            iss_last  <= 1'b0;
            rd_valid  <= 1'b0;
            rd_en     <= 1'b0;
            rd_last   <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            iss_valid <= 1'b0;
            out_valid <= 1'b0;

            if (state == IDLE && sample_tick) begin
                slot <= '0;
                sum  <= '0;
            end

            if (state == ISSUE) begin
                rom_addr  <= acc[slot][ACC_W-1 -: ADDR_W];
                rom_sel   <= voice_wave[{slot, 1'b0} +: 2];
                iss_valid <= 1'b1;
                iss_en    <= voice_en[slot];
                iss_last  <= (slot == LAST_SLOT);
                slot      <= (slot == LAST_SLOT) ? '0 : slot + 1'b1;
            end

            rd_valid <= iss_valid;
            rd_en    <= iss_en & iss_valid;
            rd_last  <= iss_last & iss_valid;

            if (rd_valid) begin
                sum <= sum_next;
                if (rd_last) begin
                    out       <= out_next;
                    out_valid <= 1'b1;
                end
            end
        end
    end

    // Sticky overrun: a tick while busy is dropped and flagged; setting beats clearing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (sample_tick && busy) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule
